// File: rtl/mem_if_pkg.sv
// Shared types and constants for the memory interface unit.
package mem_if_pkg;

    typedef enum logic [0:0] {
        IDLE,
        REQ
    } state_e;

    localparam int unsigned XLEN = 64;

    localparam logic [7:0] BE_LO  = 8'h0F;
    localparam logic [7:0] BE_HI  = 8'hF0;
    localparam logic [7:0] BE_ALL = 8'hFF;

    localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_interface_unit_load_align.sv
// Read-data steering: picks the addressed 32-bit half for the IR and builds
// the MDR value (full doubleword, or sign-extended word).
module load_align
    import mem_if_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic            off2,
    input  logic            load_word,
    output logic [31:0]     ir_slice,
    output logic [XLEN-1:0] mdr_val
);

    // Select the word lane, then extend it for word loads
    always_comb begin
        ir_slice = off2 ? rdata[63:32] : rdata[31:0];
        mdr_val  = load_word ? {{(XLEN - 32){ir_slice[31]}}, ir_slice} : rdata;
    end

endmodule

// File: rtl/mem_interface_unit.sv
// Memory-side stage behind the multi-cycle controller: drives a shared
// instruction/data memory over req/ack, holds IR and MDR, stalls via busy.
// Optional build macro MEM_TIMEOUT_EN aborts a REQ after TIMEOUT cycles.
module mem_interface_unit #(
    parameter int unsigned XLEN    = mem_if_pkg::XLEN,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = mem_if_pkg::TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic              iord,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              ir_write,
    input  logic              sw,
    input  logic              load_word,
    input  logic [XLEN-1:0]   store_data,
    output logic              busy,
    output logic              fault,
    output logic [31:0]       ir,
    output logic [XLEN-1:0]   mdr,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [XLEN-1:0]   m_wdata,
    output logic [XLEN/8-1:0] m_be,
    input  logic              m_ack,
    input  logic [XLEN-1:0]   m_rdata
);

    import mem_if_pkg::*;

    state_e            state_q;
    logic              ir_intent_q;
    logic              lw_q;
    logic              off2_q;

    logic [ADDR_W-1:0] addr_sel;
    logic              is_cmd;
    logic              is_word;
    logic              illegal;
    logic              legal;
    logic              expire;
    logic [XLEN/8-1:0] be_d;
    logic [XLEN-1:0]   wdata_d;
    logic [31:0]       ir_slice;
    logic [XLEN-1:0]   mdr_val;

    // Decode the incoming command: address, width, legality and bus lanes
    always_comb begin
        addr_sel = iord ? alu_addr : pc;
        is_cmd   = mem_read | mem_write;
        // Instruction fetches are always 32-bit, regardless of load_word
        is_word  = mem_write ? sw : (ir_write | load_word);
        illegal  = (mem_read & mem_write) |
                   (is_word ? (addr_sel[1:0] != 2'b00) : (addr_sel[2:0] != 3'b000));
        legal    = is_cmd & ~illegal;
        if (mem_write && sw) begin
            be_d    = addr_sel[2] ? BE_HI : BE_LO;
            wdata_d = {store_data[31:0], store_data[31:0]};
        end else if (mem_write) begin
            be_d    = BE_ALL;
            wdata_d = store_data;
        end else begin
            be_d    = BE_ALL;
            wdata_d = '0;
        end
    end

    // Stall while a legal command waits for acceptance or an access is open
    always_comb begin
        busy = ((state_q == IDLE) && legal) || ((state_q == REQ) && !m_ack && !expire);
    end

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CntW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CntW-1:0] cnt_q;

    // Count REQ cycles; expiry fires in the TIMEOUT-th REQ cycle
    assign expire = (state_q == REQ) && (cnt_q == CntW'(TIMEOUT - 1));

    // Restart the count on every access
    always_ff @(posedge clk) begin
        if (rst || state_q == IDLE) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign expire         = 1'b0;
    assign unused_timeout = (TIMEOUT == 0);
`endif

    load_align u_load_align (
        .rdata     (m_rdata),
        .off2      (off2_q),
        .load_word (lw_q),
        .ir_slice  (ir_slice),
        .mdr_val   (mdr_val)
    );

    // Access FSM with registered bus outputs, IR/MDR and sticky fault
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            m_req       <= 1'b0;
            m_we        <= 1'b0;
            m_addr      <= '0;
            m_wdata     <= '0;
            m_be        <= '0;
            ir_intent_q <= 1'b0;
            lw_q        <= 1'b0;
            off2_q      <= 1'b0;
            fault       <= 1'b0;
            ir          <= '0;
            mdr         <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (is_cmd && illegal) begin
                        fault <= 1'b1;
                    end else if (is_cmd) begin
                        m_addr      <= {addr_sel[ADDR_W-1:3], 3'b000};
                        m_we        <= mem_write;
                        m_be        <= be_d;
                        m_wdata     <= wdata_d;
                        ir_intent_q <= ir_write;
                        lw_q        <= load_word;
                        off2_q      <= addr_sel[2];
                        m_req       <= 1'b1;
                        state_q     <= REQ;
                    end
                end
                REQ: begin
                    // An ack in the expiry cycle takes priority over the abort
                    if (m_ack) begin
                        m_req   <= 1'b0;
                        m_we    <= 1'b0;
                        state_q <= IDLE;
                        if (!m_we && ir_intent_q) begin
                            ir <= ir_slice;
                        end else if (!m_we) begin
                            mdr <= mdr_val;
                        end
                    end else if (expire) begin
                        m_req   <= 1'b0;
                        m_we    <= 1'b0;
                        fault   <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_interface_unit.sv
// Directed bench for mem_interface_unit with hand-computed expectations.
module tb_mem_interface_unit;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] alu_addr;
    logic        iord;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        sw;
    logic        load_word;
    logic [63:0] store_data;
    logic        busy;
    logic        fault;
    logic [31:0] ir;
    logic [63:0] mdr;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [63:0] m_wdata;
    logic [7:0]  m_be;
    logic        m_ack;
    logic [63:0] m_rdata;

    int n_checks = 0;
    int n_errors = 0;
    int nbusy;

    mem_interface_unit #(
        .XLEN    (64),
        .ADDR_W  (32),
        .TIMEOUT (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .alu_addr   (alu_addr),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .sw         (sw),
        .load_word  (load_word),
        .store_data (store_data),
        .busy       (busy),
        .fault      (fault),
        .ir         (ir),
        .mdr        (mdr),
        .m_req      (m_req),
        .m_we       (m_we),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_be       (m_be),
        .m_ack      (m_ack),
        .m_rdata    (m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_cmd();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        sw        = 1'b0;
        load_word = 1'b0;
        iord      = 1'b0;
    endtask

    // Command inputs are already set; run until ack (acks after `waits` REQ cycles)
    task automatic run_access(input int waits, input logic [63:0] rdata, output int nb);
        int nreq;
        nb   = 0;
        nreq = 0;
        for (int c = 0; c < 40; c++) begin
            if (m_req) nreq++;
            if (m_req && nreq == waits + 1) begin
                m_ack   = 1'b1;
                m_rdata = rdata;
            end
            #1;
            if (busy) nb++;
            if (m_ack) begin
                @(posedge clk); #1;
                m_ack = 1'b0;
                clear_cmd();
                return;
            end
            @(posedge clk); #1;
        end
        check_val("access_bound", 64'(nreq), 64'(waits + 1));
        clear_cmd();
    endtask

    initial begin
        rst        = 1'b1;
        pc         = '0;
        alu_addr   = '0;
        store_data = '0;
        m_ack      = 1'b0;
        m_rdata    = '0;
        clear_cmd();
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_fault", 64'(fault), 64'd0);
        check_val("rst_req", 64'(m_req), 64'd0);
        check_val("rst_ir", 64'(ir), 64'd0);
        check_val("rst_mdr", mdr, 64'd0);
        check_val("rst_be", 64'(m_be), 64'd0);
        check_val("rst_addr", 64'(m_addr), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Fetch from pc=0x104, 3 wait cycles
        pc       = 32'h104;
        mem_read = 1'b1;
        ir_write = 1'b1;
        run_access(3, 64'h00A00093_DEADBEEF, nbusy);
        check_val("fetch_busy_cycles", 64'(nbusy), 64'd4);
        check_val("fetch_ir", 64'(ir), 64'h00A00093);
        check_val("fetch_mdr", mdr, 64'd0);

        // lw from 0x200, zero-wait, negative word
        iord      = 1'b1;
        alu_addr  = 32'h200;
        mem_read  = 1'b1;
        load_word = 1'b1;
        run_access(0, 64'h12345678_80000001, nbusy);
        check_val("lw_busy_cycles", 64'(nbusy), 64'd1);
        check_val("lw_mdr", mdr, 64'hFFFFFFFF_80000001);

        // lw from upper half, positive word
        iord      = 1'b1;
        alu_addr  = 32'h204;
        mem_read  = 1'b1;
        load_word = 1'b1;
        run_access(1, 64'h7FFF0000_ABCD0123, nbusy);
        check_val("lw_hi_mdr", mdr, 64'h00000000_7FFF0000);
        check_val("lw_hi_ir_kept", 64'(ir), 64'h00A00093);

        // sw to 0x24
        iord       = 1'b1;
        alu_addr   = 32'h24;
        store_data = 64'h1111_2222_3333_4444;
        mem_write  = 1'b1;
        sw         = 1'b1;
        #1;
        check_val("sw_busy_idle", 64'(busy), 64'd1);
        @(posedge clk); #1;
        check_val("sw_req", 64'(m_req), 64'd1);
        check_val("sw_addr", 64'(m_addr), 64'h20);
        check_val("sw_be", 64'(m_be), 64'hF0);
        check_val("sw_wdata", m_wdata, 64'h33334444_33334444);
        check_val("sw_we", 64'(m_we), 64'd1);
        m_ack = 1'b1;
        @(posedge clk); #1;
        m_ack = 1'b0;
        clear_cmd();
        check_val("sw_mdr_kept", mdr, 64'h00000000_7FFF0000);
        check_val("sw_req_done", 64'(m_req), 64'd0);

        // Aligned sd to 0x28
        iord       = 1'b1;
        alu_addr   = 32'h28;
        store_data = 64'hCAFE_F00D_1234_5678;
        mem_write  = 1'b1;
        @(posedge clk); #1;
        check_val("sd_be", 64'(m_be), 64'hFF);
        check_val("sd_wdata", m_wdata, 64'hCAFE_F00D_1234_5678);
        check_val("sd_addr", 64'(m_addr), 64'h28);
        m_ack = 1'b1;
        @(posedge clk); #1;
        m_ack = 1'b0;
        clear_cmd();

        // Misaligned sd to 0x12
        iord      = 1'b1;
        alu_addr  = 32'h12;
        mem_write = 1'b1;
        #1;
        check_val("missd_busy_idle", 64'(busy), 64'd0);
        @(posedge clk); #1;
        check_val("missd_req", 64'(m_req), 64'd0);
        check_val("missd_fault", 64'(fault), 64'd1);
        clear_cmd();

        // Following aligned ld still serviced
        iord     = 1'b1;
        alu_addr = 32'h18;
        mem_read = 1'b1;
        run_access(1, 64'h01234567_89ABCDEF, nbusy);
        check_val("ld_busy_cycles", 64'(nbusy), 64'd2);
        check_val("ld_mdr", mdr, 64'h01234567_89ABCDEF);
        check_val("ld_fault_sticky", 64'(fault), 64'd1);

        // Reset during the 2nd REQ cycle, with an ack in flight
        pc       = 32'h8;
        mem_read = 1'b1;
        ir_write = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_val("rreq_req", 64'(m_req), 64'd1);
        rst     = 1'b1;
        m_ack   = 1'b1;
        m_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk); #1;
        rst   = 1'b0;
        m_ack = 1'b0;
        clear_cmd();
        check_val("rreq_req_after", 64'(m_req), 64'd0);
        check_val("rreq_ir", 64'(ir), 64'd0);
        check_val("rreq_mdr", mdr, 64'd0);
        check_val("rreq_fault", 64'(fault), 64'd0);
        @(posedge clk); #1;
        check_val("rreq_ir_later", 64'(ir), 64'd0);
        check_val("rreq_busy", 64'(busy), 64'd0);

`ifdef MEM_TIMEOUT_EN
        begin
            int nreq;
            nreq     = 0;
            iord     = 1'b1;
            alu_addr = 32'h40;
            mem_read = 1'b1;
            @(posedge clk); #1;
            for (int c = 0; c < 20 && m_req; c++) begin
                nreq++;
                @(posedge clk); #1;
            end
            clear_cmd();
            check_val("to_req_cycles", 64'(nreq), 64'd4);
            check_val("to_req", 64'(m_req), 64'd0);
            check_val("to_fault", 64'(fault), 64'd1);
            check_val("to_busy", 64'(busy), 64'd0);
            check_val("to_mdr", mdr, 64'd0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
        $finish;
    end

endmodule
